// File: rtl/pipeline_regfile.sv
// Sixteen-entry 16-bit register file with write-back forwarding.
// R15 doubles as the flag register, loaded by any nonzero ALU compare word.
module pipeline_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        write,
    input  logic [3:0]  writeReg,
    input  logic [15:0] writeData,
    input  logic [3:0]  readReg0,
    output logic [15:0] readData0,
    input  logic [3:0]  readReg1,
    output logic [15:0] readData1,
    input  logic [15:0] compare
);

    logic [15:0] regs [16];
    logic        cmp_hit;
    logic        hit0;
    logic        hit1;

    assign cmp_hit = |compare;
    assign hit0    = write && (writeReg == readReg0);
    assign hit1    = write && (writeReg == readReg1);

    // The compare load is issued last so it overrides a general write to R15.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (write) begin
                regs[writeReg] <= writeData;
            end
            if (cmp_hit) begin
                regs[15] <= compare;
            end
        end
    end

    // Reads mirror the state the next edge will produce, except during reset.
    always_comb begin
        readData0 = regs[readReg0];
        if (!rst) begin
            if (readReg0 == 4'd15 && cmp_hit) begin
                readData0 = compare;
            end else if (hit0) begin
                readData0 = writeData;
            end
        end
    end

    always_comb begin
        readData1 = regs[readReg1];
        if (!rst) begin
            if (readReg1 == 4'd15 && cmp_hit) begin
                readData1 = compare;
            end else if (hit1) begin
                readData1 = writeData;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_regfile.sv
// Scoreboard bench for pipeline_regfile: directed plan plus random traffic
// checked against an array model of the next register state.
module tb_pipeline_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  writeReg = '0;
    logic [15:0] writeData = '0;
    logic [3:0]  readReg0 = '0;
    logic [15:0] readData0;
    logic [3:0]  readReg1 = '0;
    logic [15:0] readData1;
    logic [15:0] compare = '0;

    typedef struct {
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic [15:0] e0;
        logic [15:0] e1;
        string       tag;
    } item_t;

    item_t       sb[$];
    logic [15:0] model [16];
    bit          known = 1'b0;
    int          total = 0;
    int          bad = 0;

    pipeline_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .write     (write),
        .writeReg  (writeReg),
        .writeData (writeData),
        .readReg0  (readReg0),
        .readData0 (readData0),
        .readReg1  (readReg1),
        .readData1 (readData1),
        .compare   (compare)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic w,
                        input logic [3:0] wr, input logic [15:0] wd,
                        input logic [3:0] a0, input logic [3:0] a1,
                        input logic [15:0] cmp, input string tag);
        logic [15:0] nxt [16];
        item_t it;
        @(posedge clk);
        #1;
        rst = r;
        write = w;
        writeReg = wr;
        writeData = wd;
        readReg0 = a0;
        readReg1 = a1;
        compare = cmp;
        nxt = model;
        if (!r) begin
            if (w) nxt[wr] = wd;
            if (cmp != 16'h0) nxt[15] = cmp;
        end
        if (known) begin
            it.a0 = a0;
            it.a1 = a1;
            it.e0 = r ? model[a0] : nxt[a0];
            it.e1 = r ? model[a1] : nxt[a1];
            it.tag = tag;
            sb.push_back(it);
        end
        if (r) begin
            foreach (model[i]) model[i] = 16'h0;
            known = 1'b1;
        end else begin
            model = nxt;
        end
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 4'd0, 16'h0, 4'(i), 4'(15 - i), 16'h0, tag);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            item_t it;
            it = sb.pop_front();
            total += 2;
            if (readData0 !== it.e0) begin
                bad++;
                $display("FAIL %s port0 addr=%0d got=%h want=%h",
                         it.tag, it.a0, readData0, it.e0);
            end
            if (readData1 !== it.e1) begin
                bad++;
                $display("FAIL %s port1 addr=%0d got=%h want=%h",
                         it.tag, it.a1, readData1, it.e1);
            end
        end
    end

    initial begin
        foreach (model[i]) model[i] = 16'h0;
        step(1, 0, 4'd0, 16'h0, 4'd0, 4'd0, 16'h0, "reset");
        sweep("idle_zero");

        step(0, 1, 4'd0, 16'h0001, 4'd0, 4'd3, 16'h0, "r0_write");
        step(0, 0, 4'd0, 16'h0000, 4'd0, 4'd0, 16'h0, "r0_read");

        step(0, 1, 4'd1, 16'h0002, 4'd1, 4'd1, 16'h0, "fwd_same");
        step(0, 0, 4'd1, 16'h0000, 4'd1, 4'd1, 16'h0, "fwd_stored");

        step(0, 1, 4'd2, 16'h0003, 4'd2, 4'd2, 16'h0, "r2_first");
        step(0, 1, 4'd2, 16'h0004, 4'd2, 4'd15, 16'h0001, "r2_cmp");
        step(0, 0, 4'd2, 16'h0005, 4'd2, 4'd15, 16'h0, "no_write");

        step(0, 1, 4'd15, 16'hAAAA, 4'd15, 4'd15, 16'h0003, "collide");
        step(0, 0, 4'd15, 16'hAAAA, 4'd15, 4'd14, 16'h0, "collide_hold");

        step(0, 1, 4'd5, 16'h0007, 4'd5, 4'd5, 16'h0, "r5_set");
        step(1, 1, 4'd5, 16'h1234, 4'd5, 4'd15, 16'h0, "rst_nofwd");
        sweep("rst_zero");

        for (int n = 0; n < 1500; n++) begin
            logic r;
            logic w;
            logic [3:0] wr;
            logic [3:0] a0;
            logic [3:0] a1;
            logic [15:0] cmp;
            r = ($urandom_range(0, 59) == 0);
            w = $urandom_range(0, 1);
            wr = 4'($urandom);
            a0 = ($urandom_range(0, 3) == 0) ? wr : 4'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            cmp = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
            step(r, w, wr, 16'($urandom), a0, a1, cmp, "random");
        end

        step(0, 0, 4'd0, 16'h0, 4'd0, 4'd0, 16'h0, "tail");
        for (int k = 0; k < 4 && sb.size() != 0; k++) begin
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
